// File: rtl/pls_cnt_pkg.sv
// +------------------------------------------------------------------+
// | pls_cnt_pkg                                                      |
// | Shared types, defaults and helpers for the pls_cnt_mod counter.  |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none

package pls_cnt_pkg;

    typedef enum logic [1:0] {
        EV_NONE = 2'd0,
        EV_CLR  = 2'd1,
        EV_LD   = 2'd2,
        EV_CNT  = 2'd3
    } pls_ev_e;

    localparam int PLS_MOD_DEF  = 100;
    localparam int PLS_HALF_DEF = 50;

    // Clamp a preset into the legal count range 0..mod-1.
    function automatic logic [31:0] sat_mod(input logic [31:0] val, input logic [31:0] mod);
        return (val >= mod) ? (mod - 32'd1) : val;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pls_edge_det.sv
// +------------------------------------------------------------------+
// | pls_edge_det                                                     |
// | 2-FF synchroniser with rise/fall detect on the synchronised pair.|
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none

module pls_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic i_din,
    output logic o_lvl,
    output logic o_rise,
    output logic o_fall
);

    logic r_s0;
    logic r_s1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s0 <= 1'b0;
            r_s1 <= 1'b0;
        end else begin
            r_s0 <= i_din;
            r_s1 <= r_s0;
        end
    end

    assign o_lvl  = r_s1;
    assign o_rise = r_s0 & ~r_s1;
    assign o_fall = r_s1 & ~r_s0;

endmodule

`default_nettype wire

// File: rtl/pls_cnt_mod.sv
// +------------------------------------------------------------------+
// | pls_cnt_mod                                                      |
// | Modulo-MOD pulse counter with preset load, half-point square     |
// | output and terminal-count pulse. PLS_CNT_DOWN_EN adds down count.|
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none

module pls_cnt_mod
    import pls_cnt_pkg::*;
#(
    parameter int MOD  = PLS_MOD_DEF,
    parameter int HALF = MOD / 2,
    parameter int W    = $clog2(MOD)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         plsi,
    input  logic         ld,
    input  logic [W-1:0] ldval,
    input  logic         dn,
    output logic [W-1:0] qout,
    output logic         plso,
    output logic         tc
);

    localparam logic [W-1:0] c_max  = W'(MOD - 1);
    localparam logic [W-1:0] c_half = W'(HALF);

    logic         w_clr_rise;
    logic         w_ld_rise;
    logic         w_pls_fall;
    logic         w_dn;
    logic [5:0]   w_det_unused;
    logic [W-1:0] w_ld_sat;
    pls_ev_e      w_ev;
    logic [W-1:0] w_q_nxt;
    logic         w_plso_nxt;
    logic         w_tc_nxt;

    logic [W-1:0] r_q;
    logic         r_plso;
    logic         r_tc;

    pls_edge_det u_clr_det (
        .clk    (clk),
        .rst    (rst),
        .i_din  (clr),
        .o_lvl  (w_det_unused[0]),
        .o_rise (w_clr_rise),
        .o_fall (w_det_unused[1])
    );

    pls_edge_det u_pls_det (
        .clk    (clk),
        .rst    (rst),
        .i_din  (plsi),
        .o_lvl  (w_det_unused[2]),
        .o_rise (w_det_unused[3]),
        .o_fall (w_pls_fall)
    );

    pls_edge_det u_ld_det (
        .clk    (clk),
        .rst    (rst),
        .i_din  (ld),
        .o_lvl  (w_det_unused[4]),
        .o_rise (w_ld_rise),
        .o_fall (w_det_unused[5])
    );

`ifdef PLS_CNT_DOWN_EN
    logic [1:0] w_dn_unused;

    pls_edge_det u_dn_det (
        .clk    (clk),
        .rst    (rst),
        .i_din  (dn),
        .o_lvl  (w_dn),
        .o_rise (w_dn_unused[0]),
        .o_fall (w_dn_unused[1])
    );
`else
    logic w_dn_unused;

    assign w_dn_unused = dn;
    assign w_dn        = 1'b0;
`endif

    assign w_ld_sat = W'(sat_mod(32'(ldval), 32'(MOD)));

    always_comb begin
        w_ev = EV_NONE;
        if (w_clr_rise)      w_ev = EV_CLR;
        else if (w_ld_rise)  w_ev = EV_LD;
        else if (w_pls_fall) w_ev = EV_CNT;
    end

    // Wrap/borrow decisions look at the registered count, not a wrapped sum.
    always_comb begin
        w_q_nxt    = r_q;
        w_plso_nxt = r_plso;
        w_tc_nxt   = 1'b0;
        case (w_ev)
            EV_CLR: begin
                w_q_nxt    = '0;
                w_plso_nxt = 1'b0;
            end
            EV_LD: begin
                w_q_nxt    = w_ld_sat;
                w_plso_nxt = (w_ld_sat >= c_half);
            end
            EV_CNT: begin
                if (w_dn) begin
                    if (r_q == '0) begin
                        w_q_nxt  = c_max;
                        w_tc_nxt = 1'b1;
                    end else begin
                        w_q_nxt  = r_q - W'(1);
                    end
                end else begin
                    if (r_q == c_max) begin
                        w_q_nxt  = '0;
                        w_tc_nxt = 1'b1;
                    end else begin
                        w_q_nxt  = r_q + W'(1);
                    end
                end
                w_plso_nxt = (w_q_nxt >= c_half);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q    <= '0;
            r_plso <= 1'b0;
            r_tc   <= 1'b0;
        end else begin
            r_q    <= w_q_nxt;
            r_plso <= w_plso_nxt;
            r_tc   <= w_tc_nxt;
        end
    end

    assign qout = r_q;
    assign plso = r_plso;
    assign tc   = r_tc;

endmodule

`default_nettype wire

// File: tb/tb_pls_cnt_mod.sv
// +------------------------------------------------------------------+
// | tb_pls_cnt_mod                                                   |
// | Directed bench for pls_cnt_mod at MOD=100, 60 and 24.            |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none

module tb_pls_cnt_mod;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       plsi;
    logic       ld;
    logic [6:0] ldval;
    logic       dn;

    logic [6:0] q100;
    logic       plso100;
    logic       tc100;
    logic [5:0] q60;
    logic       plso60;
    logic       tc60;
    logic [4:0] q24;
    logic       plso24;
    logic       tc24;

    int n_assert;
    int n_fail;

    pls_cnt_mod #(.MOD(100), .HALF(50)) dut100 (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .plsi  (plsi),
        .ld    (ld),
        .ldval (ldval),
        .dn    (dn),
        .qout  (q100),
        .plso  (plso100),
        .tc    (tc100)
    );

    pls_cnt_mod #(.MOD(60), .HALF(30)) dut60 (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .plsi  (plsi),
        .ld    (ld),
        .ldval (ldval[5:0]),
        .dn    (dn),
        .qout  (q60),
        .plso  (plso60),
        .tc    (tc60)
    );

    pls_cnt_mod #(.MOD(24), .HALF(12)) dut24 (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .plsi  (plsi),
        .ld    (ld),
        .ldval (ldval[4:0]),
        .dn    (dn),
        .qout  (q24),
        .plso  (plso24),
        .tc    (tc24)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        rst  = 1'b0;
        clr  = 1'b0;
        ld   = 1'b0;
        plsi = 1'b1;
        tick;
        rst = 1'b1;
        tick;
        tick;
    endtask

    // One full plsi cycle: 2 clk low, 2 clk high.
    task automatic pulse;
        plsi = 1'b0;
        tick;
        tick;
        plsi = 1'b1;
        tick;
        tick;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst   = 1'b0;
        clr   = 1'b0;
        ld    = 1'b0;
        plsi  = 1'b1;
        dn    = 1'b0;
        ldval = '0;
        tick;
        tick;
        chk("reset_q",    32'(q100),    32'd0);
        chk("reset_plso", 32'(plso100), 32'd0);
        chk("reset_tc",   32'(tc100),   32'd0);
        rst = 1'b1;
        tick;
        tick;

        // Latency: first low sample at edge N, update at edge N+1
        plsi = 1'b0;
        tick;
        chk("lat_edgeN_q", 32'(q100), 32'd0);
        tick;
        chk("lat_edgeN1_q", 32'(q100), 32'd1);
        plsi = 1'b1;
        tick;
        tick;

        // Low glitch between two clock edges is never sampled
        #2 plsi = 1'b0;
        #4 plsi = 1'b1;
        tick;
        tick;
        tick;
        chk("glitch_q", 32'(q100), 32'd1);

        // Full revolution at MOD=100
        do_reset;
        for (int k = 1; k <= 100; k++) begin
            plsi = 1'b0;
            tick;
            tick;
            chk("up_q",    32'(q100),    32'(k % 100));
            chk("up_plso", 32'(plso100), 32'((k % 100) >= 50));
            chk("up_tc",   32'(tc100),   32'(k == 100));
            plsi = 1'b1;
            tick;
            chk("up_tc_next", 32'(tc100), 32'd0);
            tick;
        end

        // Load and saturation
        do_reset;
        ldval = 7'd45;
        ld    = 1'b1;
        tick;
        chk("ld_edgeN_q", 32'(q60), 32'd0);
        tick;
        chk("ld45_q60",    32'(q60),     32'd45);
        chk("ld45_plso60", 32'(plso60),  32'd1);
        chk("ld45_tc60",   32'(tc60),    32'd0);
        chk("ld45_q100",   32'(q100),    32'd45);
        chk("ld45_plso100",32'(plso100), 32'd0);
        ld = 1'b0;
        tick;
        tick;
        ldval = 7'd63;
        ld    = 1'b1;
        tick;
        tick;
        chk("ld63_q60",  32'(q60),  32'd59);
        chk("ld63_q100", 32'(q100), 32'd63);
        ld = 1'b0;
        tick;
        tick;
        plsi = 1'b0;
        tick;
        tick;
        chk("wrap59_q60",    32'(q60),    32'd0);
        chk("wrap59_tc60",   32'(tc60),   32'd1);
        chk("wrap59_plso60", 32'(plso60), 32'd0);
        chk("inc63_q100",    32'(q100),   32'd64);
        chk("inc63_tc100",   32'(tc100),  32'd0);
        plsi = 1'b1;
        tick;
        tick;
        pulse;
        chk("pre_sim_q60", 32'(q60), 32'd1);

        // Clear, load and count detected together: clear wins
        ldval = 7'd10;
        clr   = 1'b1;
        ld    = 1'b1;
        plsi  = 1'b0;
        tick;
        tick;
        chk("sim3_q60",    32'(q60),    32'd0);
        chk("sim3_plso60", 32'(plso60), 32'd0);
        chk("sim3_tc60",   32'(tc60),   32'd0);
        clr  = 1'b0;
        ld   = 1'b0;
        plsi = 1'b1;
        tick;
        tick;

        // Load with count: loaded value only, count dropped
        ldval = 7'd20;
        ld    = 1'b1;
        plsi  = 1'b0;
        tick;
        tick;
        chk("ldcnt_q60",    32'(q60),    32'd20);
        chk("ldcnt_plso60", 32'(plso60), 32'd0);
        ld   = 1'b0;
        plsi = 1'b1;
        tick;
        chk("ldcnt_hold_q60", 32'(q60), 32'd20);
        tick;

        // Down count from zero at MOD=24
        do_reset;
        dn = 1'b1;
        tick;
        tick;
        tick;
        plsi = 1'b0;
        tick;
        tick;
`ifdef PLS_CNT_DOWN_EN
        chk("dn_q24",    32'(q24),    32'd23);
        chk("dn_tc24",   32'(tc24),   32'd1);
        chk("dn_plso24", 32'(plso24), 32'd1);
`else
        chk("dn_q24",    32'(q24),    32'd1);
        chk("dn_tc24",   32'(tc24),   32'd0);
        chk("dn_plso24", 32'(plso24), 32'd0);
`endif
        plsi = 1'b1;
        tick;
        tick;
        dn = 1'b0;

        // Reset asserted while a count is in flight
        do_reset;
        for (int k = 0; k < 73; k++) pulse;
        chk("mid_q100",    32'(q100),    32'd73);
        chk("mid_plso100", 32'(plso100), 32'd1);
        plsi = 1'b0;
        tick;
        #2 rst = 1'b0;
        #1;
        chk("async_q100",    32'(q100),    32'd0);
        chk("async_plso100", 32'(plso100), 32'd0);
        chk("async_tc100",   32'(tc100),   32'd0);
        tick;
        rst = 1'b1;
        tick;
        tick;
        chk("lost_ev_q100", 32'(q100), 32'd0);
        plsi = 1'b1;
        tick;
        tick;
        plsi = 1'b0;
        tick;
        tick;
        chk("post_rst_q100", 32'(q100), 32'd1);
        plsi = 1'b1;
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
